// File: rtl/pe_scheduler.sv
// pe_scheduler: sequences one dot product through an accumulating PE.
// Clears the PE, pairs activation/weight beats into it, waits out the PE
// latency, then holds the captured result on a valid/ready output until taken.
module pe_scheduler #(
    parameter int BW     = 8,
    parameter int KW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [KW-1:0]   i_k_len,
    output logic            o_busy,
    input  logic            i_act_valid,
    output logic            o_act_ready,
    input  logic [BW-1:0]   i_activation,
    input  logic            i_wt_valid,
    output logic            o_wt_ready,
    input  logic [BW-1:0]   i_weight,
    output logic            o_pe_reset,
    output logic [BW-1:0]   o_pe_activation,
    output logic [BW-1:0]   o_pe_weight,
    input  logic [2*BW-1:0] i_pe_output,
    output logic [2*BW-1:0] o_result,
    output logic            o_result_valid,
    input  logic            i_result_ready
);

    // Drain counter must reach PE_LAT, so it needs room for PE_LAT+1 values.
    localparam int DW = $clog2(PE_LAT + 2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        HOLD
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [KW-1:0]   k_len;
    logic [KW-1:0]   count;
    logic [DW-1:0]   drain_count;
    logic            start_accept;
    logic            transfer;
    logic            capture;
    logic            pe_clear;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state handshake/status outputs.
    always_comb begin
        next_state     = state;
        start_accept   = 1'b0;
        transfer       = 1'b0;
        capture        = 1'b0;
        pe_clear       = 1'b0;
        o_busy         = 1'b1;
        o_act_ready    = 1'b0;
        o_wt_ready     = 1'b0;
        o_result_valid = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start && (i_k_len != '0)) begin
                    start_accept = 1'b1;
                    next_state   = CLEAR;
                end
            end
            CLEAR: begin
                pe_clear   = 1'b1;
                next_state = FEED;
            end
            FEED: begin
                // Each ready follows the other stream's valid, so a beat is
                // only taken when its partner is available in the same cycle.
                o_act_ready = i_wt_valid;
                o_wt_ready  = i_act_valid;
                transfer    = i_act_valid && i_wt_valid;
                if (transfer && (count == (k_len - KW'(1)))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_count == DW'(PE_LAT)) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                o_result_valid = 1'b1;
                if (i_result_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The PE is cleared by system reset as well as at the start of each job.
    assign o_pe_reset = i_reset || pe_clear;

    // Job length, transfer/drain counters, PE operand registers and result.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            k_len           <= '0;
            count           <= '0;
            drain_count     <= '0;
            o_pe_activation <= '0;
            o_pe_weight     <= '0;
            o_result        <= '0;
        end else begin
            if (start_accept) begin
                k_len <= i_k_len;
                count <= '0;
            end else if (transfer) begin
                count <= count + KW'(1);
            end

            // Operands are presented for exactly one cycle per transfer and
            // forced to zero otherwise so idle cycles add nothing to the PE.
            o_pe_activation <= transfer ? i_activation : '0;
            o_pe_weight     <= transfer ? i_weight     : '0;

            if (state == DRAIN) begin
                drain_count <= drain_count + DW'(1);
            end else begin
                drain_count <= '0;
            end

            if (capture) begin
                o_result <= i_pe_output;
            end
        end
    end

endmodule

// File: tb/tb_pe_scheduler.sv
// tb_pe_scheduler: directed bench for pe_scheduler with a behavioural
// accumulating PE (BW=8, PE_LAT=1). Table of jobs plus reset corner cases.
module tb_pe_scheduler;

    localparam int BW     = 8;
    localparam int KW     = 8;
    localparam int PE_LAT = 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            act_valid;
    logic            act_ready;
    logic [BW-1:0]   activation;
    logic            wt_valid;
    logic            wt_ready;
    logic [BW-1:0]   weight;
    logic            pe_reset;
    logic [BW-1:0]   pe_act;
    logic [BW-1:0]   pe_wt;
    logic [2*BW-1:0] pe_acc;
    logic [2*BW-1:0] result;
    logic            result_valid;
    logic            result_ready;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          k;
        logic [31:0] acts;
        logic [31:0] wts;
        int          gap;
        int          bp;
        bit          feed_start;
        logic [15:0] exp_result;
    } job_t;

    job_t jobs[7];

    pe_scheduler #(.BW(BW), .KW(KW), .PE_LAT(PE_LAT)) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_start         (start),
        .i_k_len         (k_len),
        .o_busy          (busy),
        .i_act_valid     (act_valid),
        .o_act_ready     (act_ready),
        .i_activation    (activation),
        .i_wt_valid      (wt_valid),
        .o_wt_ready      (wt_ready),
        .i_weight        (weight),
        .o_pe_reset      (pe_reset),
        .o_pe_activation (pe_act),
        .o_pe_weight     (pe_wt),
        .i_pe_output     (pe_acc),
        .o_result        (result),
        .o_result_valid  (result_valid),
        .i_result_ready  (result_ready)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Behavioural PE: accumulates act*weight every cycle, one cycle latency.
    always_ff @(posedge clock) begin
        if (pe_reset) begin
            pe_acc <= '0;
        end else begin
            pe_acc <= pe_acc + (16'(pe_act) * 16'(pe_wt));
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    // Runs one complete job from IDLE back to IDLE, checking along the way.
    task automatic applyStimulus(input job_t job);
        int          lat;
        bit          prev_xfer;
        logic [7:0]  prev_a;
        logic [7:0]  prev_w;
        logic [7:0]  a;
        logic [7:0]  w;
        start     = 1'b1;
        k_len     = 8'(job.k);
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        k_len = '0;
        #1;
        checkOutput("clear_pe_reset", 32'(pe_reset), 32'd1);
        checkOutput("clear_busy", 32'(busy), 32'd1);
        checkOutput("clear_act_ready", 32'(act_ready), 32'd0);
        tick();
        prev_xfer = 1'b0;
        prev_a    = '0;
        prev_w    = '0;
        for (int i = 0; i < job.k; i++) begin
            a = job.acts[8*(i%4) +: 8];
            w = job.wts[8*(i%4) +: 8];
            if (i > 0) begin
                for (int g = 0; g < job.gap; g++) begin
                    act_valid  = 1'b1;
                    activation = a;
                    wt_valid   = 1'b0;
                    weight     = 8'hEE;
                    #1;
                    checkOutput("gap_act_ready", 32'(act_ready), 32'd0);
                    checkOutput("gap_wt_ready", 32'(wt_ready), 32'd1);
                    checkOutput("gap_pe_act", 32'(pe_act), prev_xfer ? 32'(prev_a) : 32'd0);
                    checkOutput("gap_pe_wt", 32'(pe_wt), prev_xfer ? 32'(prev_w) : 32'd0);
                    tick();
                    prev_xfer = 1'b0;
                end
            end
            act_valid  = 1'b1;
            wt_valid   = 1'b1;
            activation = a;
            weight     = w;
            if (job.feed_start && i == 1) begin
                start = 1'b1;
                k_len = 8'd2;
            end
            #1;
            checkOutput("feed_act_ready", 32'(act_ready), 32'd1);
            checkOutput("feed_wt_ready", 32'(wt_ready), 32'd1);
            checkOutput("feed_pe_act", 32'(pe_act), prev_xfer ? 32'(prev_a) : 32'd0);
            checkOutput("feed_pe_wt", 32'(pe_wt), prev_xfer ? 32'(prev_w) : 32'd0);
            prev_a    = a;
            prev_w    = w;
            prev_xfer = 1'b1;
            tick();
            start = 1'b0;
            k_len = '0;
        end
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        #1;
        checkOutput("drain_pe_act", 32'(pe_act), 32'(prev_a));
        checkOutput("drain_pe_wt", 32'(pe_wt), 32'(prev_w));
        checkOutput("drain_act_ready", 32'(act_ready), 32'd0);
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("result_latency", 32'(lat), 32'(2 + PE_LAT));
        checkOutput("result_value", 32'(result), 32'(job.exp_result));
        for (int b = 0; b < job.bp; b++) begin
            tick();
            checkOutput("bp_valid", 32'(result_valid), 32'd1);
            checkOutput("bp_result", 32'(result), 32'(job.exp_result));
        end
        result_ready = 1'b1;
        #1;
        checkOutput("hs_valid", 32'(result_valid), 32'd1);
        tick();
        result_ready = 1'b0;
        #1;
        checkOutput("post_busy", 32'(busy), 32'd0);
        checkOutput("post_valid", 32'(result_valid), 32'd0);
        checkOutput("post_result_held", 32'(result), 32'(job.exp_result));
    endtask

    // Main sequence: reset, job table, then the reset/ignore corner cases.
    initial begin
        job_t one;
        int   lat;
        jobs[0] = '{3,   32'h00040201, 32'h00050301, 0, 0, 1'b0, 16'd27};
        jobs[1] = '{3,   32'h00040201, 32'h00050301, 2, 0, 1'b0, 16'd27};
        jobs[2] = '{3,   32'h00040201, 32'h00050301, 0, 5, 1'b0, 16'd27};
        jobs[3] = '{3,   32'h00040201, 32'h00050301, 0, 0, 1'b1, 16'd27};
        jobs[4] = '{2,   32'h0000FFFF, 32'h0000FFFF, 0, 0, 1'b0, 16'hFC02};
        jobs[5] = '{4,   32'h0A070003, 32'h00010902, 1, 1, 1'b0, 16'd13};
        jobs[6] = '{255, 32'h01010101, 32'h01010101, 0, 0, 1'b0, 16'd255};

        reset        = 1'b1;
        start        = 1'b0;
        k_len        = '0;
        act_valid    = 1'b1;
        wt_valid     = 1'b1;
        activation   = 8'h55;
        weight       = 8'h66;
        result_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_pe_reset", 32'(pe_reset), 32'd1);
        checkOutput("rst_act_ready", 32'(act_ready), 32'd0);
        checkOutput("rst_wt_ready", 32'(wt_ready), 32'd0);
        checkOutput("rst_pe_act", 32'(pe_act), 32'd0);
        reset     = 1'b0;
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        tick();
        checkOutput("idle_pe_reset", 32'(pe_reset), 32'd0);

        for (int j = 0; j < 7; j++) begin
            applyStimulus(jobs[j]);
        end

        // A zero-length start is ignored.
        start = 1'b1;
        k_len = 8'd0;
        tick();
        start = 1'b0;
        #1;
        checkOutput("k0_busy", 32'(busy), 32'd0);
        checkOutput("k0_pe_reset", 32'(pe_reset), 32'd0);
        tick();
        checkOutput("k0_busy_later", 32'(busy), 32'd0);

        // Reset after 2 of 4 transfers aborts the job.
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start = 1'b0;
        tick();
        act_valid  = 1'b1;
        wt_valid   = 1'b1;
        activation = 8'd1;
        weight     = 8'd1;
        tick();
        tick();
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        reset     = 1'b1;
        #1;
        checkOutput("midrst_pe_reset", 32'(pe_reset), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_valid", 32'(result_valid), 32'd0);
        checkOutput("midrst_result", 32'(result), 32'd0);
        checkOutput("midrst_pe_act", 32'(pe_act), 32'd0);
        tick();
        checkOutput("midrst_no_valid", 32'(result_valid), 32'd0);
        one = '{1, 32'h00000007, 32'h00000009, 0, 0, 1'b0, 16'd63};
        applyStimulus(one);

        // Reset while holding a result drops it without a handshake.
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        tick();
        act_valid  = 1'b1;
        wt_valid   = 1'b1;
        activation = 8'd2;
        weight     = 8'd3;
        tick();
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("holdrst_reached", 32'(result_valid), 32'd1);
        checkOutput("holdrst_value", 32'(result), 32'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("holdrst_valid", 32'(result_valid), 32'd0);
        checkOutput("holdrst_result", 32'(result), 32'd0);
        checkOutput("holdrst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        checkOutput("holdrst_stays_idle", 32'(result_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
